// File: rtl/laplacian_pkg.sv
// Shared defaults and FSM encoding for the laplacian window front end.
package laplacian_pkg;

    localparam int DEFAULT_WIDTH      = 24;
    localparam int DEFAULT_PIC_WIDTH  = 480;
    localparam int DEFAULT_PIC_HEIGHT = 272;
    localparam int DEFAULT_CNT_W      = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/line_buffer_ram.sv
// Single-port row buffer: asynchronous read of the old word, write of the new word on the same edge.
module line_buffer_ram #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 480,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // NOTE: storage arrays take no reset; PRIME overwrites every word before it is read as a tap.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/laplacian_window_ctrl.sv
// Raster-to-column-triple sequencer feeding the 3x3 laplacian matrix stage.
module laplacian_window_ctrl
    import laplacian_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PIC_WIDTH  = DEFAULT_PIC_WIDTH,
    parameter int PIC_HEIGHT = DEFAULT_PIC_HEIGHT,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sof,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             tap_valid,
    output logic [WIDTH-1:0] tap_top,
    output logic [WIDTH-1:0] tap_mid,
    output logic [WIDTH-1:0] tap_bot,
    output logic [CNT_W-1:0] tap_col,
    output logic [CNT_W-1:0] tap_row,
    output logic             win_ok,
    output logic             frame_done,
    output logic             busy,
    output logic             err_sof
);

    localparam int               AW       = $clog2(PIC_WIDTH);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(PIC_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(PIC_HEIGHT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] col, row, col_next, row_next;
    logic [CNT_W-1:0] pix_col, pix_row;
    logic             accept, restart, emit_tap;
    logic [WIDTH-1:0] lb0_rdata, lb1_rdata;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        pix_col    = col;
        pix_row    = row;
        accept     = 1'b0;
        restart    = 1'b0;
        emit_tap   = 1'b0;

        // A qualified sof always relabels the pixel as (0,0), whatever the counters say.
        case (state)
            IDLE: begin
                if (sof && in_valid) begin
                    accept  = 1'b1;
                    pix_col = '0;
                    pix_row = '0;
                end
            end
            PRIME, STREAM: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (sof) begin
                        restart = 1'b1;
                        pix_col = '0;
                        pix_row = '0;
                    end
                end
            end
            default: ;
        endcase

        if (accept) begin
            if (pix_col == LAST_COL) begin
                col_next = '0;
                row_next = pix_row + 1'b1;
            end else begin
                col_next = pix_col + 1'b1;
                row_next = pix_row;
            end
        end

        case (state)
            IDLE: if (accept) state_next = PRIME;
            PRIME: begin
                if (accept && !restart && pix_row == CNT_W'(1) && pix_col == LAST_COL)
                    state_next = STREAM;
            end
            STREAM: begin
                if (restart) begin
                    state_next = PRIME;
                end else if (accept) begin
                    emit_tap = 1'b1;
                    if (pix_row == LAST_ROW && pix_col == LAST_COL) begin
                        state_next = DONE;
                        col_next   = '0;
                        row_next   = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            col   <= col_next;
            row   <= row_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_valid  <= 1'b0;
            tap_top    <= '0;
            tap_mid    <= '0;
            tap_bot    <= '0;
            tap_col    <= '0;
            tap_row    <= '0;
            win_ok     <= 1'b0;
            frame_done <= 1'b0;
            err_sof    <= 1'b0;
        end else begin
            tap_valid  <= emit_tap;
            win_ok     <= emit_tap && (pix_col >= CNT_W'(2));
            frame_done <= (state == DONE);
            err_sof    <= restart;
            if (emit_tap) begin
                tap_top <= lb1_rdata;
                tap_mid <= lb0_rdata;
                tap_bot <= in_data;
                tap_col <= pix_col;
                tap_row <= pix_row;
            end
        end
    end

    assign busy = (state == PRIME) || (state == STREAM);

    // lb0 holds row-1; its old word shifts into lb1 (row-2) on the same edge.
    line_buffer_ram #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .AW(AW)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (pix_col[AW-1:0]),
        .wdata (in_data),
        .rdata (lb0_rdata)
    );

    line_buffer_ram #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .AW(AW)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (pix_col[AW-1:0]),
        .wdata (lb0_rdata),
        .rdata (lb1_rdata)
    );

endmodule

// File: doc/laplacian_window_ctrl.md
Name: laplacian_window_ctrl

Overview:
Front-end sequencer for the 3x3 matrix/laplacian datapath. It accepts a raster pixel stream, stores the two previous rows in line buffers, and tracks row and column position. For every accepted pixel from row 2 onward it emits a column-aligned triple (top/mid/bot), which drives the din1/din2/din3 inputs of the matrix stage. It also flags window validity, frame completion and protocol errors.

Parameters:
WIDTH, 24, pixel width in bits (RGB888).
PIC_WIDTH, 480, pixels per row.
PIC_HEIGHT, 272, rows per frame.
CNT_W, 9, width of the column and row counters; must satisfy 2^CNT_W > max(PIC_WIDTH, PIC_HEIGHT).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
sof  in  1  start-of-frame pulse; qualifies the in_valid pixel in the same cycle as pixel (0,0).
in_valid  in  1  pixel strobe; no backpressure.
in_data  in  WIDTH  pixel value.
tap_valid  out  1  tap outputs are valid this cycle.
tap_top  out  WIDTH  pixel (row-2, col).
tap_mid  out  WIDTH  pixel (row-1, col).
tap_bot  out  WIDTH  pixel (row, col), which is the current input.
tap_col  out  CNT_W  column of the current tap.
tap_row  out  CNT_W  row of the current tap.
win_ok  out  1  tap_valid and tap_col >= 2, meaning the downstream 3x3 window is fully populated.
frame_done  out  1  one-cycle pulse after the last pixel of the frame.
busy  out  1  high in PRIME and STREAM.
err_sof  out  1  one-cycle pulse when sof arrives mid-frame.

Behaviour:
- Reset values: all outputs are 0, state = IDLE, counters = 0. Line buffer contents are not reset, and are don't-care because of the PRIME state.
- FSM states and transitions:
  - IDLE: wait for sof & in_valid. That pixel is accepted as (0,0) and the state moves to PRIME. in_valid without sof is ignored.
  - PRIME: rows 0 and 1 are written to the line buffers; tap_valid = 0. On the last pixel of row 1, move to STREAM.
  - STREAM: each accepted pixel produces a tap. On pixel (PIC_HEIGHT-1, PIC_WIDTH-1), move to DONE.
  - DONE: frame_done = 1 for one cycle, then IDLE. A sof in DONE is ignored.
- Counters:
  - col increments on each accepted pixel. At PIC_WIDTH-1 it wraps to 0 and row increments.
  - in_valid = 0 holds all state; the stream may stall arbitrarily.
- Line buffers: two RAMs, depth PIC_WIDTH, addressed by col, using read-old/write-new on the same cycle.
  - lb0 holds row-1 and lb1 holds row-2.
  - On an accepted pixel: lb1[col] <= lb0[col], and lb0[col] <= in_data.
- Latency: taps are registered, 1 cycle after the accepting edge.
  - tap_top = old lb1[col], tap_mid = old lb0[col], tap_bot = in_data.
  - tap_col and tap_row are the indices of that accepted pixel.
  - tap_valid is deasserted in the cycle following a non-accept.
- Mid-frame sof (sof & in_valid in PRIME or STREAM):
  - err_sof pulses.
  - Counters restart with that pixel as (0,0), and the state goes to PRIME.
  - frame_done does not pulse.
- sof without in_valid: ignored in every state.
- Reset mid-frame: return immediately to IDLE; taps and pulses drop asynchronously.
- Arithmetic: counter comparisons use CNT_W-bit unsigned values. There is no pixel arithmetic in this block.

Decomposition:
- Shared package (laplacian_pkg): PIC_WIDTH, PIC_HEIGHT, CNT_W, WIDTH defaults, and state encodings (IDLE=2'd0, PRIME=2'd1, STREAM=2'd2, DONE=2'd3).
- One sub-module: line_buffer_ram (single-port, read-before-write, parameterised on WIDTH and depth), instantiated twice.

Test Plan:
All scenarios use sim params PIC_WIDTH=4, PIC_HEIGHT=4 and pixel value = row*16+col.
1. Full frame, continuous in_valid with sof on the first pixel:
   - No taps for rows 0–1.
   - 8 taps for rows 2–3.
   - Tap (2,3): top=0x03, mid=0x13, bot=0x23, win_ok=1.
   - Tap (2,1): win_ok=0.
   - frame_done pulses exactly once, 1 cycle after tap (3,3).
2. Same frame with in_valid toggled 1-0-1:
   - Identical tap sequence, but with gaps.
   - tap_valid=0 in the cycle after each gap cycle; counters hold.
3. sof re-asserted at pixel (2,1):
   - err_sof pulses; state returns to PRIME; no frame_done.
   - The following full frame yields correct taps (top of (2,0) = 0x00).
4. in_valid without sof in IDLE for 10 cycles: busy=0, no taps, counters stay 0.
5. rst_n asserted during STREAM at tap (3,1):
   - All outputs are 0 asynchronously.
   - After release and a new sof, a correct full frame is produced.
6. Back-to-back frames, second sof one cycle after frame_done: the second frame's taps use only the second frame's data (tap (2,0) top=0x00, mid=0x10).
